// File: rtl/transformer_stage_scheduler.sv
// Sequences the encoder (MHA, FFN) and decoder (SELF, CROSS, FFN) stage units
// layer by layer, with per-stage timeout, abort and sticky error reporting.
module transformer_stage_scheduler #(
  parameter int MAX_LAYERS = 8,
  parameter int TO_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      cfg_enc_layers,
  input  logic [3:0]      cfg_dec_layers,
  input  logic [TO_W-1:0] cfg_timeout,
  output logic [4:0]      stage_start,
  input  logic [4:0]      stage_done,
  output logic [2:0]      layer_idx,
  output logic [3:0]      wbank,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err_code,
  output logic [2:0]      err_stage
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [2:0] ENC_MHA   = 3'd0;
  localparam logic [2:0] ENC_FFN   = 3'd1;
  localparam logic [2:0] DEC_SELF  = 3'd2;
  localparam logic [2:0] DEC_CROSS = 3'd3;
  localparam logic [2:0] DEC_FFN   = 3'd4;
  localparam logic [3:0] MAX_L     = 4'(MAX_LAYERS);

  state_t            state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [2:0]        layer_q, layer_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [3:0]        enc_q, enc_d;
  logic [3:0]        dec_q, dec_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              done_q, done_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [2:0]        err_stage_q, err_stage_d;

  logic [4:0] stage_onehot;
  logic       cur_done;
  logic       bad_cfg;
  logic       enc_last;
  logic       dec_last;

  assign stage_onehot = 5'b00001 << stage_q;
  assign cur_done     = |(stage_done & stage_onehot);
  assign bad_cfg      = ((cfg_enc_layers == 4'd0) && (cfg_dec_layers == 4'd0)) ||
                        (cfg_enc_layers > MAX_L) || (cfg_dec_layers > MAX_L);
  assign enc_last     = (({1'b0, layer_q} + 4'd1) == enc_q);
  assign dec_last     = (({1'b0, layer_q} + 4'd1) == dec_q);

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    layer_d     = layer_q;
    timer_d     = timer_q;
    enc_d       = enc_q;
    dec_d       = dec_q;
    to_d        = to_q;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    err_stage_d = err_stage_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            err_code_d  = 2'b11;
            err_stage_d = 3'd7;
            done_d      = 1'b1;
          end else begin
            enc_d       = cfg_enc_layers;
            dec_d       = cfg_dec_layers;
            to_d        = cfg_timeout;
            err_code_d  = 2'b00;
            err_stage_d = 3'd0;
            layer_d     = 3'd0;
            stage_d     = (cfg_enc_layers != 4'd0) ? ENC_MHA : DEC_SELF;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        if (abort) begin
          err_code_d  = 2'b10;
          err_stage_d = stage_q;
          done_d      = 1'b1;
          state_d     = FINISH;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // Priority: abort, then the current stage's done, then timeout.
        if (abort) begin
          err_code_d  = 2'b10;
          err_stage_d = stage_q;
          done_d      = 1'b1;
          state_d     = FINISH;
        end else if (cur_done) begin
          state_d = ISSUE;
          unique case (stage_q)
            ENC_MHA: stage_d = ENC_FFN;
            ENC_FFN: begin
              if (!enc_last) begin
                stage_d = ENC_MHA;
                layer_d = layer_q + 3'd1;
              end else if (dec_q == 4'd0) begin
                done_d  = 1'b1;
                state_d = FINISH;
              end else begin
                stage_d = DEC_SELF;
                layer_d = 3'd0;
              end
            end
            DEC_SELF:  stage_d = DEC_CROSS;
            DEC_CROSS: stage_d = DEC_FFN;
            DEC_FFN: begin
              if (dec_last) begin
                done_d  = 1'b1;
                state_d = FINISH;
              end else begin
                stage_d = DEC_SELF;
                layer_d = layer_q + 3'd1;
              end
            end
            default: begin
              done_d  = 1'b1;
              state_d = FINISH;
            end
          endcase
        end else if ((to_q != '0) && (timer_q == (to_q - 1'b1))) begin
          err_code_d  = 2'b01;
          err_stage_d = stage_q;
          done_d      = 1'b1;
          state_d     = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= ENC_MHA;
      layer_q     <= 3'd0;
      timer_q     <= '0;
      done_q      <= 1'b0;
      err_code_q  <= 2'b00;
      err_stage_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      layer_q     <= layer_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      err_code_q  <= err_code_d;
      err_stage_q <= err_stage_d;
    end
    enc_q <= enc_d;
    dec_q <= dec_d;
    to_q  <= to_d;
  end

  // An abort arriving in the ISSUE cycle must kill that cycle's start pulse.
  assign stage_start = ((state_q == ISSUE) && !abort) ? stage_onehot : 5'd0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign layer_idx   = layer_q;
  assign wbank       = {(stage_q >= DEC_SELF), layer_q};
  assign err_code    = err_code_q;
  assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_transformer_stage_scheduler.sv
// Self-checking bench for transformer_stage_scheduler: directed scenarios plus
// randomized runs compared against a stage-list timing model.
module tb_transformer_stage_scheduler;
  localparam int TO_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [3:0]      cfg_enc_layers;
  logic [3:0]      cfg_dec_layers;
  logic [TO_W-1:0] cfg_timeout;
  logic [4:0]      stage_start;
  logic [4:0]      stage_done;
  logic [2:0]      layer_idx;
  logic [3:0]      wbank;
  logic            busy;
  logic            done;
  logic [1:0]      err_code;
  logic [2:0]      err_stage;

  int checks = 0;
  int failures = 0;

  int          plan_d[40];
  int          st_cyc[$];
  logic [4:0]  st_val[$];
  logic [3:0]  st_wb[$];
  int          done_cyc;
  int          busy_cnt;
  int          onehot_errs;
  logic [1:0]  done_err;
  logic [1:0]  first_err;
  logic [2:0]  done_es;
  logic [4:0]  abort_ss;
  logic        post_busy;
  logic        post_done;

  transformer_stage_scheduler #(.MAX_LAYERS(8), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_enc_layers(cfg_enc_layers), .cfg_dec_layers(cfg_dec_layers),
    .cfg_timeout(cfg_timeout), .stage_start(stage_start), .stage_done(stage_done),
    .layer_idx(layer_idx), .wbank(wbank), .busy(busy), .done(done),
    .err_code(err_code), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  // Issues one run and plays the stage units: each started stage answers after
  // plan_d[n] cycles; unrelated done bits carry random noise.
  task automatic exec_run(input int enc, input int dec, input int to,
                          input int abort_rel, input bit fin_start, input int max_cyc);
    int pend_cyc;
    int pend_bit;
    int nstart;
    logic [4:0] sd;
    st_cyc.delete(); st_val.delete(); st_wb.delete();
    done_cyc = -1; busy_cnt = 0; onehot_errs = 0;
    done_err = 2'b00; done_es = 3'd0; abort_ss = 5'h1f; first_err = 2'b00;
    pend_cyc = -1; pend_bit = 0; nstart = 0;
    @(negedge clk);
    cfg_enc_layers = 4'(enc); cfg_dec_layers = 4'(dec); cfg_timeout = TO_W'(to);
    start = 1'b1;
    for (int rel = 1; rel <= max_cyc; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        start = 1'b0;
        cfg_enc_layers = 4'($urandom);
        cfg_dec_layers = 4'($urandom);
        cfg_timeout = TO_W'($urandom);
        first_err = err_code;
      end
      if (busy) busy_cnt++;
      if (stage_start != 5'd0) begin
        st_cyc.push_back(rel); st_val.push_back(stage_start); st_wb.push_back(wbank);
        if ($countones(stage_start) != 1) onehot_errs++;
        for (int b = 0; b < 5; b++) if (stage_start[b]) pend_bit = b;
        pend_cyc = rel + plan_d[nstart % 40];
        nstart++;
      end
      if (rel == abort_rel) begin
        abort = 1'b1;
        #1 abort_ss = stage_start;
      end else begin
        abort = 1'b0;
      end
      sd = 5'($urandom) & ~(5'd1 << pend_bit);
      if (rel == pend_cyc) sd = sd | (5'd1 << pend_bit);
      if ((stage_start != 5'd0) && ($urandom_range(0, 1) == 1)) sd = sd | stage_start;
      stage_done = sd;
      if (done) begin
        done_cyc = rel; done_err = err_code; done_es = err_stage;
        if (fin_start) begin
          start = 1'b1; cfg_enc_layers = 4'd1; cfg_dec_layers = 4'd0;
        end
        break;
      end
    end
    @(negedge clk);
    post_busy = busy; post_done = done;
    start = 1'b0; abort = 1'b0; stage_done = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (stage_start !== 5'd0) begin failures++; $display("FAIL reset_stage_start got=%b exp=00000", stage_start); end
    checks++;
    if (layer_idx !== 3'd0) begin failures++; $display("FAIL reset_layer_idx got=%0d exp=0", layer_idx); end
    checks++;
    if (wbank !== 4'd0) begin failures++; $display("FAIL reset_wbank got=%b exp=0000", wbank); end
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++;
    if ({err_code, err_stage} !== 5'd0) begin failures++; $display("FAIL reset_err got=%b_%b exp=00_000", err_code, err_stage); end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ec[5] = '{1, 5, 9, 13, 17};
    logic [4:0] ev[5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    logic [3:0] ew[5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 40; i++) plan_d[i] = 3;
    exec_run(1, 1, 0, -1, 1'b0, 60);
    if (st_cyc.size() !== 5) begin failures++; $display("FAIL basic_nstarts got=%0d exp=5", st_cyc.size()); end
    checks++;
    for (int i = 0; i < 5 && i < st_cyc.size(); i++) begin
      if ({st_cyc[i], st_val[i], st_wb[i]} !== {ec[i], ev[i], ew[i]}) begin
        failures++;
        $display("FAIL basic_start%0d got=cyc%0d/%b/%b exp=cyc%0d/%b/%b", i, st_cyc[i], st_val[i], st_wb[i], ec[i], ev[i], ew[i]);
      end
      checks++;
    end
    if ({done_cyc, done_err} !== {32'sd21, 2'b00}) begin failures++; $display("FAIL basic_done got=cyc%0d err%b exp=cyc21 err00", done_cyc, done_err); end
    checks++;
    if (busy_cnt !== 21) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=21", busy_cnt); end
    checks++;
    if ({post_busy, post_done} !== 2'b00) begin failures++; $display("FAIL basic_after got=%b exp=00", {post_busy, post_done}); end
    checks++;
  endtask

  task automatic test_multi_layer();
    logic [4:0] ev[4] = '{5'b00001, 5'b00010, 5'b00001, 5'b00010};
    logic [3:0] ew[4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
    for (int i = 0; i < 40; i++) plan_d[i] = $urandom_range(1, 4);
    exec_run(2, 0, 0, -1, 1'b0, 60);
    if (st_cyc.size() !== 4) begin failures++; $display("FAIL multi_nstarts got=%0d exp=4", st_cyc.size()); end
    checks++;
    for (int i = 0; i < 4 && i < st_cyc.size(); i++) begin
      if ({st_val[i], st_wb[i]} !== {ev[i], ew[i]}) begin
        failures++;
        $display("FAIL multi_start%0d got=%b/%b exp=%b/%b", i, st_val[i], st_wb[i], ev[i], ew[i]);
      end
      checks++;
    end
    if ((done_cyc < 0) || (done_err !== 2'b00)) begin failures++; $display("FAIL multi_done got=cyc%0d err%b exp=done err00", done_cyc, done_err); end
    checks++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 40; i++) plan_d[i] = 3;
    plan_d[1] = 1000;
    exec_run(1, 1, 5, -1, 1'b1, 60);
    if (st_cyc.size() !== 2) begin failures++; $display("FAIL timeout_nstarts got=%0d exp=2", st_cyc.size()); end
    checks++;
    if ({done_cyc, done_err, done_es} !== {32'sd11, 2'b01, 3'd1}) begin
      failures++; $display("FAIL timeout_done got=cyc%0d err%b stg%0d exp=cyc11 err01 stg1", done_cyc, done_err, done_es);
    end
    checks++;
    if ({post_busy, post_done} !== 2'b00) begin failures++; $display("FAIL finish_start_ignored got=%b exp=00", {post_busy, post_done}); end
    checks++;
    for (int i = 0; i < 40; i++) plan_d[i] = 5;
    exec_run(1, 0, 5, -1, 1'b0, 40);
    if ({done_cyc, done_err} !== {32'sd13, 2'b00}) begin failures++; $display("FAIL timeout_tie got=cyc%0d err%b exp=cyc13 err00", done_cyc, done_err); end
    checks++;
  endtask

  task automatic test_abort();
    logic [1:0] e_idle;
    for (int i = 0; i < 40; i++) plan_d[i] = 3;
    exec_run(1, 1, 0, 14, 1'b0, 60);
    if ({done_cyc, done_err, done_es} !== {32'sd15, 2'b10, 3'd3}) begin
      failures++; $display("FAIL abort_wait got=cyc%0d err%b stg%0d exp=cyc15 err10 stg3", done_cyc, done_err, done_es);
    end
    checks++;
    @(negedge clk); abort = 1'b1;
    repeat (2) @(negedge clk);
    e_idle = err_code;
    if ({e_idle, busy, done} !== 4'b1000) begin failures++; $display("FAIL abort_idle_sticky got=%b exp=1000", {e_idle, busy, done}); end
    checks++;
    abort = 1'b0;
    exec_run(1, 0, 0, -1, 1'b0, 40);
    if ({first_err, done_err} !== 4'b0000) begin failures++; $display("FAIL abort_clear got=%b/%b exp=00/00", first_err, done_err); end
    checks++;
    exec_run(1, 0, 0, 1, 1'b0, 20);
    if (abort_ss !== 5'd0) begin failures++; $display("FAIL abort_issue_suppress got=%b exp=00000", abort_ss); end
    checks++;
    if ({done_cyc, done_err, done_es} !== {32'sd2, 2'b10, 3'd0}) begin
      failures++; $display("FAIL abort_issue got=cyc%0d err%b stg%0d exp=cyc2 err10 stg0", done_cyc, done_err, done_es);
    end
    checks++;
  endtask

  task automatic test_bad_cfg();
    int ce[3] = '{0, 9, 1};
    int cd[3] = '{0, 1, 9};
    for (int k = 0; k < 3; k++) begin
      exec_run(ce[k], cd[k], 0, -1, 1'b0, 5);
      if ({done_cyc, done_err, done_es} !== {32'sd1, 2'b11, 3'd7}) begin
        failures++; $display("FAIL badcfg%0d got=cyc%0d err%b stg%0d exp=cyc1 err11 stg7", k, done_cyc, done_err, done_es);
      end
      checks++;
      if ({busy_cnt, st_cyc.size(), post_busy} !== {32'd0, 32'd0, 1'b0}) begin
        failures++; $display("FAIL badcfg%0d_busy got=busy%0d starts%0d exp=0/0", k, busy_cnt, st_cyc.size());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    stage_done = 5'd0;
    @(negedge clk);
    cfg_enc_layers = 4'd1; cfg_dec_layers = 4'd1; cfg_timeout = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if ({stage_start, layer_idx, wbank, busy, done, err_code, err_stage} !== 20'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%0d/%b/%b/%b/%b/%0d exp=all zero", stage_start, layer_idx, wbank, busy, done, err_code, err_stage);
    end
    checks++;
    seen_done = 0;
    repeat (5) begin @(negedge clk); if (done || busy) seen_done++; end
    if (seen_done !== 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", seen_done); end
    checks++;
    for (int i = 0; i < 40; i++) plan_d[i] = 3;
    exec_run(1, 1, 0, -1, 1'b0, 60);
    if ({done_cyc, done_err, st_cyc.size()} !== {32'sd21, 2'b00, 32'd5}) begin
      failures++; $display("FAIL rst_mid_rerun got=cyc%0d err%b starts%0d exp=cyc21 err00 starts5", done_cyc, done_err, st_cyc.size());
    end
    checks++;
  endtask

  task automatic test_random_runs();
    int enc, dec, to, t, exp_done, n;
    int stg[$];
    int lay[$];
    int exp_c[$];
    logic [4:0] exp_v[$];
    logic [3:0] exp_w[$];
    logic [1:0] exp_err;
    logic [2:0] exp_es;
    for (int it = 0; it < 20; it++) begin
      enc = $urandom_range(0, 8);
      dec = $urandom_range(0, 8);
      if (enc == 0 && dec == 0) enc = 1;
      to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 7);
      for (int i = 0; i < 40; i++) begin
        plan_d[i] = $urandom_range(1, 6);
        if (to != 0 && $urandom_range(0, 19) == 0) plan_d[i] = 1000;
      end
      stg.delete(); lay.delete(); exp_c.delete(); exp_v.delete(); exp_w.delete();
      for (int l = 0; l < enc; l++) begin stg.push_back(0); lay.push_back(l); stg.push_back(1); lay.push_back(l); end
      for (int l = 0; l < dec; l++)
        for (int s = 2; s < 5; s++) begin stg.push_back(s); lay.push_back(l); end
      t = 1; exp_done = -1; exp_err = 2'b00; exp_es = 3'd0;
      for (int i = 0; i < stg.size() && exp_done < 0; i++) begin
        exp_c.push_back(t);
        exp_v.push_back(5'd1 << stg[i]);
        exp_w.push_back({(stg[i] >= 2), 3'(lay[i])});
        if (to != 0 && plan_d[i] > to) begin
          exp_done = t + to + 1; exp_err = 2'b01; exp_es = 3'(stg[i]);
        end else begin
          t = t + plan_d[i] + 1;
        end
      end
      if (exp_done < 0) exp_done = t;
      exec_run(enc, dec, to, -1, 1'b0, 400);
      if (st_cyc.size() !== exp_c.size()) begin
        failures++; $display("FAIL rand%0d_nstarts got=%0d exp=%0d", it, st_cyc.size(), exp_c.size());
      end
      checks++;
      n = (st_cyc.size() < exp_c.size()) ? st_cyc.size() : exp_c.size();
      for (int i = 0; i < n; i++) begin
        if ({st_cyc[i], st_val[i], st_wb[i]} !== {exp_c[i], exp_v[i], exp_w[i]}) begin
          failures++;
          $display("FAIL rand%0d_start%0d got=cyc%0d/%b/%b exp=cyc%0d/%b/%b", it, i, st_cyc[i], st_val[i], st_wb[i], exp_c[i], exp_v[i], exp_w[i]);
        end
        checks++;
      end
      if ({done_cyc, done_err, done_es} !== {exp_done, exp_err, exp_es}) begin
        failures++;
        $display("FAIL rand%0d_done got=cyc%0d err%b stg%0d exp=cyc%0d err%b stg%0d", it, done_cyc, done_err, done_es, exp_done, exp_err, exp_es);
      end
      checks++;
      if ({busy_cnt, onehot_errs, post_busy} !== {exp_done, 32'd0, 1'b0}) begin
        failures++; $display("FAIL rand%0d_busy got=busy%0d onehot_err%0d exp=busy%0d onehot_err0", it, busy_cnt, onehot_errs, exp_done);
      end
      checks++;
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; stage_done = 5'd0;
    cfg_enc_layers = 4'd0; cfg_dec_layers = 4'd0; cfg_timeout = '0;
    test_reset();
    test_basic();
    test_multi_layer();
    test_timeout();
    test_abort();
    test_bad_cfg();
    test_reset_mid_run();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/transformer_stage_scheduler.md
TRANSFORMER_STAGE_SCHEDULER -- requirements
Module: transformer_stage_scheduler

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 8, the maximum layers per encoder or decoder stack.
REQ-002 SHALL have parameter TO_W, default 16, the timeout counter width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: run request, accepted only in IDLE.
REQ-006 SHALL have port abort, input, 1: cancels the run in progress.
REQ-007 SHALL have port cfg_enc_layers, input, 4: number of encoder layers (0..MAX_LAYERS).
REQ-008 SHALL have port cfg_dec_layers, input, 4: number of decoder layers (0..MAX_LAYERS).
REQ-009 SHALL have port cfg_timeout, input, TO_W: per-stage cycle limit; 0 disables the timeout.
REQ-010 SHALL have port stage_start, output, 5: one-hot start pulse; bit0 ENC_MHA, bit1 ENC_FFN, bit2 DEC_SELF, bit3 DEC_CROSS, bit4 DEC_FFN.
REQ-011 SHALL have port stage_done, input, 5: done indication from each stage unit, same bit order.
REQ-012 SHALL have port layer_idx, output, 3: current layer within the active stack.
REQ-013 SHALL have port wbank, output, 4: FFN/attention weight-bank select, {is_decoder, layer_idx}.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle end-of-run pulse, for both success and error.
REQ-016 SHALL have port err_code, output, 2: 00 ok, 01 timeout, 10 abort, 11 bad config; sticky until the next accepted start.
REQ-017 SHALL have port err_stage, output, 3: index 0..4 of the stage active at error; 7 for bad config.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and FINISH.
REQ-019 In IDLE with start=1: cfg_enc_layers, cfg_dec_layers and cfg_timeout SHALL be latched; config changes during a run SHALL have no effect.
REQ-020 Bad config SHALL be either both layer counts 0 or either count >MAX_LAYERS; on bad config: err_code=11, err_stage=7, done pulse in the next cycle, FSM stays IDLE.
REQ-021 On a good config: layer_idx=0, first stage = ENC_MHA if cfg_enc_layers>0, else DEC_SELF; FSM goes to ISSUE.
REQ-022 ISSUE SHALL last exactly 1 cycle: drive the stage_start bit for the current stage, clear the timer, go to WAIT.
REQ-023 In WAIT the timer SHALL increment each cycle and only stage_done[current] SHALL be sampled; other done bits, and any done in the ISSUE cycle, SHALL be ignored.
REQ-024 On stage_done[current]=1 in WAIT: the next state SHALL be ISSUE for the successor stage, so the next start pulse comes exactly 1 cycle after done.
REQ-025 Stage order per encoder layer SHALL be ENC_MHA -> ENC_FFN.
REQ-026 Stage order per decoder layer SHALL be DEC_SELF -> DEC_CROSS -> DEC_FFN.
REQ-027 Transitions after the last stage of a layer:
- after ENC_FFN of the last encoder layer: go to DEC_SELF with layer_idx reset to 0, or to FINISH if cfg_dec_layers=0;
- after DEC_FFN of the last decoder layer: go to FINISH.
REQ-028 Timeout: in WAIT, when cfg_timeout!=0 and the timer equals cfg_timeout-1 without done, set err_code=01 and err_stage=current stage, then go to FINISH.
REQ-029 If done and timeout occur in the same cycle, done SHALL win.
REQ-030 abort=1 in ISSUE or WAIT SHALL:
- set err_code=10 and err_stage=current stage;
- go to FINISH next cycle, taking priority over done and timeout;
- suppress any stage_start pulse in that cycle.
REQ-031 abort in IDLE or FINISH SHALL be ignored.
REQ-032 FINISH SHALL last 1 cycle with done=1, then go to IDLE; start seen in FINISH SHALL be ignored.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 wbank SHALL update in the same cycle as stage_start and stay stable through WAIT.
REQ-035 stage_start SHALL be zero outside ISSUE and SHALL never have more than one bit set.

Reset
REQ-036 rst=1 SHALL force IDLE from any state, including mid-run; no done pulse SHALL be produced.
REQ-037 Reset values SHALL be: stage_start=0, layer_idx=0, wbank=0, busy=0, done=0, err_code=00, err_stage=0, timer=0.

Verification
REQ-038 Basic run: enc=1, dec=1, timeout=0, each stage_done 3 cycles after its start, start at cycle 0 -> stage_start 00001,00010,00100,01000,10000 at cycles 1,5,9,13,17; done=1 at cycle 21; busy high cycles 1..21; err_code=00.
REQ-039 Multi-layer run: enc=2, dec=0 -> four starts: ENC_MHA/ENC_FFN with wbank 0000, then with wbank 0001; no decoder stage; done with err_code=00.
REQ-040 Timeout: enc=1, dec=1, timeout=5, ENC_FFN never done -> FINISH after 5 WAIT cycles; err_code=01, err_stage=1; no further starts.
REQ-041 Abort: abort pulsed while waiting on DEC_CROSS -> done next cycle, err_code=10, err_stage=3; a later start is accepted and err_code clears to 00.
REQ-042 Bad config: enc=0, dec=0 -> done at cycle 1, err_code=11, err_stage=7, busy stays 0.
REQ-043 Reset mid-run: rst during WAIT of ENC_MHA -> all outputs at reset values next cycle, no done; start with same config then completes normally.
